// File: rtl/scoreboard_ctrl.sv
// rtl/scoreboard_ctrl.sv - N-player BCD score keeper, win detect and blinking 7-segment driver
module scoreboard_ctrl #(
    parameter int NUM_PLAYERS    = 2,
    parameter int DIGITS         = 2,
    parameter int WIN_SCORE      = 11,
    parameter int BLINK_DIV      = 25_000_000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int BLANK_LZ       = 1,
    localparam int WID = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            clear,
    input  logic                            enable,
    input  logic [NUM_PLAYERS-1:0]          point,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
    output logic [NUM_PLAYERS*DIGITS*7-1:0] segments,
    output logic                            gameover,
    output logic [WID-1:0]                  winner
);

    localparam int SW = DIGITS * 4;
    localparam int BW = $clog2(10 ** DIGITS);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] WIN_B    = BW'(WIN_SCORE);
    localparam logic [BW-1:0] MAX_B    = BW'(10 ** DIGITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic {ST_PLAY, ST_OVER} state_t;

    // Patterns are built active-low and flipped at the very end for common-cathode boards.
    function automatic logic [6:0] seg_pol(input logic [6:0] pat);
        return (ACTIVE_LOW_SEG != 0) ? pat : ~pat;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] b);
        logic [6:0] p;
        case (b)
            4'd0:    p = 7'b100_0000;
            4'd1:    p = 7'b111_1001;
            4'd2:    p = 7'b010_0100;
            4'd3:    p = 7'b011_0000;
            4'd4:    p = 7'b001_1001;
            4'd5:    p = 7'b001_0010;
            4'd6:    p = 7'b000_0010;
            4'd7:    p = 7'b111_1000;
            4'd8:    p = 7'b000_0000;
            4'd9:    p = 7'b001_1000;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // All-zero score display: units show "0", higher digits blank when leading zeros are hidden.
    function automatic logic [NUM_PLAYERS*DIGITS*7-1:0] seg_reset_val();
        logic [NUM_PLAYERS*DIGITS*7-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                v[(i*DIGITS+d)*7 +: 7] = seg_pol((BLANK_LZ != 0 && d > 0) ? 7'h7F : 7'h40);
            end
        end
        return v;
    endfunction

    localparam logic [NUM_PLAYERS*DIGITS*7-1:0] SEG_RST = seg_reset_val();

    // BCD +1 with digit carries; an all-nines score holds instead of rolling over.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        logic          all9;
        r     = v;
        carry = 1'b1;
        all9  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            all9 = all9 && (v[d*4 +: 4] == 4'd9);
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return all9 ? v : r;
    endfunction

    state_t                          state_q, state_d;
    logic [WID-1:0]                  winner_q, winner_d;
    logic [NUM_PLAYERS*SW-1:0]       score_q, score_d;
    logic [BW-1:0]                   bin_q [NUM_PLAYERS];
    logic [BW-1:0]                   bin_d [NUM_PLAYERS];
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            phase_q, phase_d;
    logic [NUM_PLAYERS*DIGITS*7-1:0] seg_q, seg_d;

    logic           hit;
    logic [WID-1:0] win_idx;
    logic           lz;
    logic [3:0]     dig;
    logic [6:0]     pat;

    // State, score, blink and segment registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_PLAY;
            winner_q <= '0;
            score_q  <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                bin_q[i] <= '0;
            end
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            seg_q    <= SEG_RST;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            score_q  <= score_d;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                bin_q[i] <= bin_d[i];
            end
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
        end
    end

    // Next-state: clear wins over everything; scoring and win detect in PLAY, blink timing in OVER.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        score_d  = score_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        hit      = 1'b0;
        win_idx  = '0;
        if (clear) begin
            state_d  = ST_PLAY;
            winner_d = '0;
            score_d  = '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                bin_d[i] = '0;
            end
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (enable) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (point[i]) begin
                                score_d[i*SW +: SW] = bcd_inc(score_q[i*SW +: SW]);
                                if (bin_q[i] != MAX_B) begin
                                    bin_d[i] = bin_q[i] + 1'b1;
                                end
                            end
                        end
                    end
                    // Scan downwards so the lowest winning index is the one kept.
                    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
                        if (bin_q[i] == WIN_B) begin
                            hit     = 1'b1;
                            win_idx = WID'(i);
                        end
                    end
                    if (hit) begin
                        state_d  = ST_OVER;
                        winner_d = win_idx;
                    end
                end
                ST_OVER: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_PLAY;
            endcase
        end
    end

    // Segment image from the registered scores, with leading-zero and winner-blink blanking.
    always_comb begin
        seg_d = '0;
        lz    = 1'b0;
        dig   = '0;
        pat   = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            lz = 1'b1;
            for (int d = DIGITS - 1; d >= 0; d--) begin
                dig = score_q[(i*DIGITS+d)*4 +: 4];
                lz  = lz && (dig == 4'd0);
                pat = seg_enc(dig);
                if (BLANK_LZ != 0 && d > 0 && lz) begin
                    pat = 7'h7F;
                end
                if (state_q == ST_OVER && phase_q && winner_q == WID'(i)) begin
                    pat = 7'h7F;
                end
                seg_d[(i*DIGITS+d)*7 +: 7] = seg_pol(pat);
            end
        end
    end

    assign score_bcd = score_q;
    assign segments  = seg_q;
    assign gameover  = (state_q == ST_OVER);
    assign winner    = winner_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb/tb_scoreboard_ctrl.sv - table-driven self-checking bench for scoreboard_ctrl
module tb_scoreboard_ctrl;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic        enable;
    logic [1:0]  point;
    logic [15:0] score_bcd;
    logic [27:0] segments;
    logic        gameover;
    logic [0:0]  winner;

    logic        point_s;
    logic [3:0]  score_s;
    logic [6:0]  seg_s;
    logic        gameover_s;
    logic [0:0]  winner_s;

    int n_tests;
    int n_fail;

    scoreboard_ctrl #(.BLINK_DIV(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .enable    (enable),
        .point     (point),
        .score_bcd (score_bcd),
        .segments  (segments),
        .gameover  (gameover),
        .winner    (winner)
    );

    scoreboard_ctrl #(.NUM_PLAYERS(1), .DIGITS(1), .WIN_SCORE(9), .BLINK_DIV(4)) u_sat (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (1'b0),
        .enable    (1'b1),
        .point     (point_s),
        .score_bcd (score_s),
        .segments  (seg_s),
        .gameover  (gameover_s),
        .winner    (winner_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       en;
        logic [1:0] pt;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       go;
        logic       win;
    } vec_t;

    vec_t vecs[$];

    localparam logic [27:0] SEG_RST = {7'h7F, 7'h40, 7'h7F, 7'h40};

    function automatic logic [7:0] bcd(input int k);
        return 8'((k / 10) * 16 + (k % 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int v = lo; v < hi; v++) begin
            clear  = vecs[v].clr;
            enable = vecs[v].en;
            point  = vecs[v].pt;
            tick();
            chk($sformatf("vec%0d p0", v), 64'(score_bcd[7:0]), 64'(vecs[v].e0));
            chk($sformatf("vec%0d p1", v), 64'(score_bcd[15:8]), 64'(vecs[v].e1));
            chk($sformatf("vec%0d gameover", v), 64'(gameover), 64'(vecs[v].go));
            chk($sformatf("vec%0d winner", v), 64'(winner), 64'(vecs[v].win));
        end
    endtask

    int split;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        clear   = 1'b0;
        enable  = 1'b0;
        point   = 2'b00;
        point_s = 1'b0;

        // Part A: ten P0 points with an ignored one (enable low) and a P1 point.
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h01, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 8'h01, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 8'h01, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h01, 8'h01, 1'b0, 1'b0});
        for (int k = 2; k <= 10; k++) begin
            vecs.push_back('{1'b0, 1'b1, 2'b01, bcd(k), 8'h01, 1'b0, 1'b0});
        end
        split = vecs.size();
        // Part B: clear beats a point, then simultaneous points to a tied win.
        vecs.push_back('{1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0});
        for (int k = 1; k <= 11; k++) begin
            vecs.push_back('{1'b0, 1'b1, 2'b11, bcd(k), bcd(k), 1'b0, 1'b0});
        end
        vecs.push_back('{1'b0, 1'b1, 2'b00, 8'h11, 8'h11, 1'b1, 1'b0});

        repeat (2) tick();
        chk("rst score", 64'(score_bcd), 64'h0);
        chk("rst seg", 64'(segments), 64'(SEG_RST));
        chk("rst gameover", 64'(gameover), 64'h0);
        chk("rst winner", 64'(winner), 64'h0);
        resetn = 1'b1;
        enable = 1'b1;

        // Saturation: all-nines score accepts a point while still in PLAY without wrapping.
        point_s = 1'b1;
        repeat (9) tick();
        chk("sat score9", 64'(score_s), 64'h9);
        chk("sat go pre", 64'(gameover_s), 64'h0);
        tick();
        point_s = 1'b0;
        chk("sat hold", 64'(score_s), 64'h9);
        chk("sat go", 64'(gameover_s), 64'h1);
        chk("sat seg", 64'(seg_s), 64'h18);

        run_vecs(0, split);
        point = 2'b00;
        tick();
        chk("seg 10/01", 64'(segments), 64'({7'h7F, 7'h79, 7'h79, 7'h40}));

        run_vecs(split, vecs.size());

        // Winner P0 blinks with period 4; P1 steady and its late point ignored.
        for (int k = 1; k <= 16; k++) begin
            point = (k == 2) ? 2'b10 : 2'b00;
            tick();
            chk($sformatf("blink%0d seg", k), 64'(segments),
                64'({7'h79, 7'h79, ((((k - 1) / 4) % 2) == 1) ? {7'h7F, 7'h7F} : {7'h79, 7'h79}}));
            chk($sformatf("blink%0d score", k), 64'(score_bcd), 64'h1111);
        end

        clear = 1'b1;
        point = 2'b01;
        tick();
        chk("clr score", 64'(score_bcd), 64'h0);
        chk("clr gameover", 64'(gameover), 64'h0);
        chk("clr winner", 64'(winner), 64'h0);
        clear = 1'b0;
        point = 2'b00;
        tick();
        chk("clr dropped", 64'(score_bcd), 64'h0);
        chk("clr seg", 64'(segments), 64'(SEG_RST));

        // Player 1 wins alone, then asynchronous reset lands mid-blink.
        point = 2'b10;
        repeat (11) tick();
        point = 2'b00;
        tick();
        chk("p1 gameover", 64'(gameover), 64'h1);
        chk("p1 winner", 64'(winner), 64'h1);
        repeat (6) tick();
        chk("p1 blink seg", 64'(segments), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        enable = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async score", 64'(score_bcd), 64'h0);
        chk("async seg", 64'(segments), 64'(SEG_RST));
        chk("async gameover", 64'(gameover), 64'h0);
        chk("async winner", 64'(winner), 64'h0);
        chk("async sat", 64'(score_s), 64'h0);
        #20;
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
